// File: rtl/eth_frame_builder.sv
// eth_frame_builder
//   Transmit-side L2 frame builder. Takes one header descriptor per frame
//   (dest/src MAC, optional 802.1Q tag, EtherType) and a byte-aligned payload
//   AXI4-Stream. Emits the complete frame (no FCS) on an AXI4-Stream master.
//   The header is prepended and the payload is re-aligned across 64-bit beats.
//
//   Build option: define ETH_TX_PAD_EN to zero-pad frames shorter than
//   60 bytes up to exactly 60 bytes. Without it, output length is
//   header length + payload length.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   s_hdr_*                header descriptor (valid/ready), accepted only in IDLE
//   s_axis_*               payload stream slave, byte 0 in [7:0]
//   m_axis_*               frame stream master, registered outputs
module eth_frame_builder #(
   parameter int          DATA_WIDTH = 64,
   parameter logic [15:0] TPID       = 16'h8100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [47:0] s_hdr_dest_mac,
   input  logic [47:0] s_hdr_src_mac,
   input  logic [15:0] s_hdr_ethertype,
   input  logic        s_hdr_vlan_en,
   input  logic [11:0] s_hdr_vlan_id,
   input  logic        s_hdr_valid,
   output logic        s_hdr_ready,
   input  logic [63:0] s_axis_tdata,
   input  logic [7:0]  s_axis_tkeep,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic        s_axis_tlast,
   output logic [63:0] m_axis_tdata,
   output logic [7:0]  m_axis_tkeep,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast
);

   if (DATA_WIDTH != 64) begin : g_bad_width
      $error("eth_frame_builder: only DATA_WIDTH=64 is supported");
   end

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_FLUSH, S_PAD, S_LAST} state_t;

   function automatic logic [7:0] keep_of(input logic [3:0] n);
      logic [8:0] m;
      m = (9'd1 << n) - 9'd1;
      return m[7:0];
   endfunction

   function automatic logic [63:0] lane_mask(input logic [7:0] keep);
      logic [63:0] m;
      for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{keep[i]}};
      return m;
   endfunction

   function automatic logic [3:0] popcnt(input logic [7:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < 8; i++) c = c + {3'b0, v[i]};
      return c;
   endfunction

   // Header in wire order, converted to lane order (wire byte k in lane k).
   function automatic logic [143:0] pack_hdr(input logic [47:0] dst, input logic [47:0] src,
                                             input logic [15:0] et, input logic tag,
                                             input logic [11:0] vid);
      logic [143:0] wire_be;
      logic [143:0] lanes;
      wire_be = tag ? {dst, src, TPID, 4'h0, vid, et} : {dst, src, et, 32'h0};
      for (int k = 0; k < 18; k++) lanes[8*k +: 8] = wire_be[143-8*k -: 8];
      return lanes;
   endfunction

   state_t        state_q, state_d;
   logic [143:0]  hdr_q, hdr_d;
   logic          vlan_q, vlan_d;
   logic          hdr_idx_q, hdr_idx_d;
   logic          hdr_rdy_q, hdr_rdy_d;
   logic [63:0]   res_q, res_d;
   logic [3:0]    fl_cnt_q, fl_cnt_d;
   logic [63:0]   m_data_q, m_data_d;
   logic [7:0]    m_keep_q, m_keep_d;
   logic          m_valid_q, m_valid_d;
   logic          m_last_q, m_last_d;

   logic          load_en, hdr_fire, pay_fire, hdr_last, fits;
   logic [3:0]    pc, off, room, fin_n;
   logic [7:0]    fin_keep;
   logic          fin_last, fin_pad;
   logic [63:0]   merged, res_next;

   assign load_en  = !m_valid_q || m_axis_tready;
   assign hdr_fire = (state_q == S_IDLE) && hdr_rdy_q && s_hdr_valid;
   assign pay_fire = (state_q == S_DATA) && load_en && s_axis_tvalid;
   assign hdr_last = (hdr_idx_q == vlan_q);   // 1 header beat untagged, 2 tagged
   assign pc       = popcnt(s_axis_tkeep);
   assign off      = vlan_q ? 4'd2 : 4'd6;
   assign room     = 4'd8 - off;
   assign fits     = (pc <= room);
   // Byte count of the last content beat (data tail or flushed residual).
   assign fin_n    = (state_q == S_FLUSH) ? fl_cnt_q : off + pc;
   assign merged   = vlan_q ? {s_axis_tdata[47:0], res_q[15:0]} : {s_axis_tdata[15:0], res_q[47:0]};
   assign res_next = vlan_q ? {48'h0, s_axis_tdata[63:48]} : {16'h0, s_axis_tdata[63:16]};

`ifdef ETH_TX_PAD_EN
   function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {13'b0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   logic [15:0] cnt_q, cnt_d;
   logic [16:0] fin_total;
   assign fin_total = {1'b0, cnt_q} + {13'b0, fin_n};

   // A short frame's last content beat is widened to a full beat of zeros,
   // unless it already covers byte 59, in which case it ends the frame there.
   always_comb begin
      fin_keep = keep_of(fin_n);
      fin_last = 1'b1;
      fin_pad  = 1'b0;
      if (fin_total < 17'd60) begin
         if (cnt_q >= 16'd56) begin
            fin_keep = 8'h0F;
         end else begin
            fin_keep = 8'hFF;
            fin_last = 1'b0;
            fin_pad  = 1'b1;
         end
      end
   end
`else
   assign fin_keep = keep_of(fin_n);
   assign fin_last = 1'b1;
   assign fin_pad  = 1'b0;
`endif

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (hdr_fire) state_d = S_HDR;
         S_HDR:   if (load_en && hdr_last) state_d = S_DATA;
         S_DATA:  if (pay_fire && s_axis_tlast) begin
            if (!fits)        state_d = S_FLUSH;
            else if (fin_pad) state_d = S_PAD;
            else              state_d = S_LAST;
         end
         S_FLUSH: if (load_en) state_d = fin_pad ? S_PAD : S_LAST;
`ifdef ETH_TX_PAD_EN
         S_PAD:   if (load_en && cnt_q >= 16'd56) state_d = S_LAST;
`endif
         S_LAST:  if (m_axis_tready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output / datapath logic
   always_comb begin
      hdr_d     = hdr_q;
      vlan_d    = vlan_q;
      hdr_idx_d = hdr_idx_q;
      res_d     = res_q;
      fl_cnt_d  = fl_cnt_q;
      m_data_d  = m_data_q;
      m_keep_d  = m_keep_q;
      m_last_d  = m_last_q;
      m_valid_d = m_valid_q && !m_axis_tready;
      hdr_rdy_d = (state_d == S_IDLE);
`ifdef ETH_TX_PAD_EN
      cnt_d     = cnt_q;
`endif
      case (state_q)
         S_IDLE: if (hdr_fire) begin
            hdr_d     = pack_hdr(s_hdr_dest_mac, s_hdr_src_mac, s_hdr_ethertype,
                                 s_hdr_vlan_en, s_hdr_vlan_id);
            vlan_d    = s_hdr_vlan_en;
            hdr_idx_d = 1'b0;
`ifdef ETH_TX_PAD_EN
            cnt_d     = '0;
`endif
         end
         S_HDR: if (load_en) begin
            m_data_d  = hdr_idx_q ? hdr_q[127:64] : hdr_q[63:0];
            m_keep_d  = 8'hFF;
            m_last_d  = 1'b0;
            m_valid_d = 1'b1;
            hdr_idx_d = 1'b1;
            // Header bytes past the pure-header beats seed the residual.
            res_d     = vlan_q ? {48'h0, hdr_q[143:128]} : hdr_q[127:64];
`ifdef ETH_TX_PAD_EN
            cnt_d     = sat_add(cnt_q, 4'd8);
`endif
         end
         S_DATA: if (pay_fire) begin
            m_valid_d = 1'b1;
            res_d     = res_next;
            if (s_axis_tlast && fits) begin
               m_data_d = merged & lane_mask(keep_of(fin_n));
               m_keep_d = fin_keep;
               m_last_d = fin_last;
`ifdef ETH_TX_PAD_EN
               cnt_d    = sat_add(cnt_q, fin_pad ? 4'd8 : fin_n);
`endif
            end else begin
               m_data_d = merged;
               m_keep_d = 8'hFF;
               m_last_d = 1'b0;
               fl_cnt_d = pc - room;
`ifdef ETH_TX_PAD_EN
               cnt_d    = sat_add(cnt_q, 4'd8);
`endif
            end
         end
         S_FLUSH: if (load_en) begin
            m_data_d  = res_q & lane_mask(keep_of(fin_n));
            m_keep_d  = fin_keep;
            m_last_d  = fin_last;
            m_valid_d = 1'b1;
`ifdef ETH_TX_PAD_EN
            cnt_d     = sat_add(cnt_q, fin_pad ? 4'd8 : fin_n);
`endif
         end
`ifdef ETH_TX_PAD_EN
         S_PAD: if (load_en) begin
            m_data_d  = '0;
            m_keep_d  = (cnt_q >= 16'd56) ? 8'h0F : 8'hFF;
            m_last_d  = (cnt_q >= 16'd56);
            m_valid_d = 1'b1;
            cnt_d     = sat_add(cnt_q, 4'd8);
         end
`endif
         default: ;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hdr_q     <= '0;
         vlan_q    <= 1'b0;
         hdr_idx_q <= 1'b0;
         hdr_rdy_q <= 1'b0;
         res_q     <= '0;
         fl_cnt_q  <= '0;
         m_data_q  <= '0;
         m_keep_q  <= '0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
`ifdef ETH_TX_PAD_EN
         cnt_q     <= '0;
`endif
      end else begin
         hdr_q     <= hdr_d;
         vlan_q    <= vlan_d;
         hdr_idx_q <= hdr_idx_d;
         hdr_rdy_q <= hdr_rdy_d;
         res_q     <= res_d;
         fl_cnt_q  <= fl_cnt_d;
         m_data_q  <= m_data_d;
         m_keep_q  <= m_keep_d;
         m_valid_q <= m_valid_d;
         m_last_q  <= m_last_d;
`ifdef ETH_TX_PAD_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

   assign s_hdr_ready   = hdr_rdy_q;
   assign s_axis_tready = (state_q == S_DATA) && load_en;
   assign m_axis_tdata  = m_data_q;
   assign m_axis_tkeep  = m_keep_q;
   assign m_axis_tvalid = m_valid_q;
   assign m_axis_tlast  = m_last_q;

   a_full_keep: assert property (@(posedge clk) disable iff (!rst_n)
      (s_axis_tvalid && s_axis_tready && !s_axis_tlast) |-> (s_axis_tkeep == 8'hFF));
   a_min_byte: assert property (@(posedge clk) disable iff (!rst_n)
      (s_axis_tvalid && s_axis_tready) |-> s_axis_tkeep[0]);
   a_contig_keep: assert property (@(posedge clk) disable iff (!rst_n)
      (s_axis_tvalid && s_axis_tready) |-> ((s_axis_tkeep & (s_axis_tkeep + 8'd1)) == 8'd0));

endmodule

// File: tb/tb_eth_frame_builder.sv
// Self-checking bench for eth_frame_builder: stimulus pushes expected beats
// from a byte-level frame model into a queue; a monitor pops and compares.
module tb_eth_frame_builder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [47:0] s_hdr_dest_mac, s_hdr_src_mac;
   logic [15:0] s_hdr_ethertype;
   logic        s_hdr_vlan_en;
   logic [11:0] s_hdr_vlan_id;
   logic        s_hdr_valid, s_hdr_ready;
   logic [63:0] s_axis_tdata;
   logic [7:0]  s_axis_tkeep;
   logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
   logic [63:0] m_axis_tdata;
   logic [7:0]  m_axis_tkeep;
   logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;

   always #5 clk = ~clk;

   eth_frame_builder dut (
      .clk(clk), .rst_n(rst_n),
      .s_hdr_dest_mac(s_hdr_dest_mac), .s_hdr_src_mac(s_hdr_src_mac),
      .s_hdr_ethertype(s_hdr_ethertype), .s_hdr_vlan_en(s_hdr_vlan_en),
      .s_hdr_vlan_id(s_hdr_vlan_id), .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
   );

   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
   } beat_t;

   beat_t exp_q[$];
   int    errors = 0;
   int    checks = 0;
   int    rdy_mode = 0;   // 0: always ready, 1: alternate, 2: random
   int    beat_no = 0;

   localparam logic [47:0] T_DST = 48'h001122334455;
   localparam logic [47:0] T_SRC = 48'h66778899AABB;

   function automatic logic [63:0] kmask(input logic [7:0] k);
      logic [63:0] m;
      for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{k[i]}};
      return m;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model: frame as a byte list in wire order, then cut into beats.
   task automatic push_expected(input logic [47:0] d, input logic [47:0] s, input logic [15:0] et,
                                input logic tag, input logic [11:0] vid, input logic [7:0] p[$]);
      logic [7:0] f[$];
      for (int i = 0; i < 6; i++) f.push_back(d[47-8*i -: 8]);
      for (int i = 0; i < 6; i++) f.push_back(s[47-8*i -: 8]);
      if (tag) begin
         f.push_back(8'h81); f.push_back(8'h00);
         f.push_back({4'h0, vid[11:8]}); f.push_back(vid[7:0]);
      end
      f.push_back(et[15:8]); f.push_back(et[7:0]);
      foreach (p[i]) f.push_back(p[i]);
`ifdef ETH_TX_PAD_EN
      while (f.size() < 60) f.push_back(8'h00);
`endif
      for (int b = 0; b < f.size(); b += 8) begin
         beat_t e;
         e.data = '0;
         e.keep = '0;
         for (int j = 0; j < 8; j++) begin
            if (b + j < f.size()) begin
               e.data[8*j +: 8] = f[b+j];
               e.keep[j] = 1'b1;
            end
         end
         e.last = (b + 8 >= f.size());
         exp_q.push_back(e);
      end
   endtask

   // Driver tasks are entered and left at a falling edge.
   task automatic send_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] et,
                           input logic tag, input logic [11:0] vid);
      int n = 0;
      bit done = 0;
      s_hdr_dest_mac = d; s_hdr_src_mac = s; s_hdr_ethertype = et;
      s_hdr_vlan_en = tag; s_hdr_vlan_id = vid; s_hdr_valid = 1'b1;
      while (!done) begin
         #2;
         if (s_hdr_ready) done = 1;
         else if (++n > 2000) begin
            errors++; checks++;
            $display("FAIL hdr_timeout: s_hdr_ready=0 after %0d cycles, required 1", n);
            done = 1;
         end
         @(negedge clk);
      end
      s_hdr_valid = 1'b0;
   endtask

   task automatic send_beat(input logic [63:0] data, input logic [7:0] keep, input logic last,
                            input bit gaps);
      int n = 0;
      bit done = 0;
      while (!done) begin
         if (gaps && $urandom_range(0, 2) == 0) s_axis_tvalid = 1'b0;
         else begin
            s_axis_tvalid = 1'b1; s_axis_tdata = data; s_axis_tkeep = keep; s_axis_tlast = last;
         end
         #2;
         if (s_axis_tvalid && s_axis_tready) done = 1;
         else if (++n > 2000) begin
            errors++; checks++;
            $display("FAIL pay_timeout: s_axis_tready=0 after %0d cycles, required 1", n);
            done = 1;
         end
         @(negedge clk);
      end
      s_axis_tvalid = 1'b0;
   endtask

   task automatic send_pay(input logic [7:0] p[$], input bit gaps);
      for (int b = 0; b < p.size(); b += 8) begin
         logic [63:0] data;
         logic [7:0]  keep;
         data = {$urandom, $urandom};   // lanes past the last byte carry junk
         keep = '0;
         for (int j = 0; j < 8; j++) begin
            if (b + j < p.size()) begin
               data[8*j +: 8] = p[b+j];
               keep[j] = 1'b1;
            end
         end
         send_beat(data, keep, (b + 8 >= p.size()), gaps);
      end
   endtask

   task automatic send_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] et,
                             input logic tag, input logic [11:0] vid, input logic [7:0] p[$],
                             input bit gaps);
      push_expected(d, s, et, tag, vid, p);
      send_hdr(d, s, et, tag, vid);
      send_pay(p, gaps);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() > 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending_beats", 64'(exp_q.size()), 64'd0);
      repeat (3) @(negedge clk);
   endtask

   // Monitor / scoreboard
   initial begin
      logic  held;
      beat_t hb;
      beat_t e;
      held = 1'b0;
      m_axis_tready = 1'b0;
      forever begin
         @(negedge clk);
         case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (!rst_n) begin
            held = 1'b0;
            continue;
         end
         if (held) begin
            checks++;
            if (!m_axis_tvalid || m_axis_tdata !== hb.data || m_axis_tkeep !== hb.keep ||
                m_axis_tlast !== hb.last) begin
               errors++;
               $display("FAIL hold_stable: valid=%b data=%h keep=%h last=%b, required valid=1 data=%h keep=%h last=%b",
                        m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, hb.data, hb.keep, hb.last);
            end
         end
         if (m_axis_tvalid && !m_axis_tready) check("stall_s_axis_tready", 64'(s_axis_tready), 64'd0);
         if (m_axis_tvalid && m_axis_tready) begin
            held = 1'b0;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat: data=%h keep=%h last=%b, no beat expected",
                        m_axis_tdata, m_axis_tkeep, m_axis_tlast);
            end else begin
               e = exp_q.pop_front();
               if ((m_axis_tdata & kmask(e.keep)) !== e.data || m_axis_tkeep !== e.keep ||
                   m_axis_tlast !== e.last) begin
                  errors++;
                  $display("FAIL beat%0d: data=%h keep=%h last=%b, required data=%h keep=%h last=%b",
                           beat_no, m_axis_tdata & kmask(e.keep), m_axis_tkeep, m_axis_tlast,
                           e.data, e.keep, e.last);
               end
            end
            beat_no++;
         end else if (m_axis_tvalid) begin
            held = 1'b1;
            hb.data = m_axis_tdata; hb.keep = m_axis_tkeep; hb.last = m_axis_tlast;
         end else begin
            held = 1'b0;
         end
      end
   end

   // Stimulus
   initial begin
      logic [7:0] p[$];
      rst_n = 1'b0;
      s_hdr_dest_mac = '0; s_hdr_src_mac = '0; s_hdr_ethertype = '0;
      s_hdr_vlan_en = 1'b0; s_hdr_vlan_id = '0; s_hdr_valid = 1'b0;
      s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;

      repeat (3) @(negedge clk);
      #1;
      check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
      check("rst_m_tdata", m_axis_tdata, 64'd0);
      check("rst_m_tkeep", 64'(m_axis_tkeep), 64'd0);
      check("rst_s_hdr_ready", 64'(s_hdr_ready), 64'd0);
      check("rst_s_axis_tready", 64'(s_axis_tready), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("post_rst_s_hdr_ready", 64'(s_hdr_ready), 64'd1);
      @(negedge clk);

      // Untagged, 8-byte payload
      p.delete();
      for (int i = 0; i < 8; i++) p.push_back(8'(i));
      send_frame(T_DST, T_SRC, 16'h0800, 1'b0, 12'h000, p, 1'b0);
      // Tagged, 6-byte payload
      p.delete();
      for (int i = 0; i < 6; i++) p.push_back(8'(i));
      send_frame(T_DST, T_SRC, 16'h86DD, 1'b1, 12'h123, p, 1'b0);
      // Untagged, 24-byte payload, ends with a residual flush
      p.delete();
      for (int i = 0; i < 24; i++) p.push_back(8'(8'h40 + i));
      send_frame(T_DST, T_SRC, 16'h0800, 1'b0, 12'h000, p, 1'b0);
      wait_drain();

      // Backpressure alternating plus source gaps
      rdy_mode = 1;
      p.delete();
      for (int i = 0; i < 8; i++) p.push_back(8'(i));
      send_frame(T_DST, T_SRC, 16'h0800, 1'b0, 12'h000, p, 1'b1);
      wait_drain();

      // Random frames, random backpressure
      rdy_mode = 2;
      for (int f = 0; f < 40; f++) begin
         int len;
         len = $urandom_range(1, 80);
         p.delete();
         for (int i = 0; i < len; i++) p.push_back(8'($urandom));
         send_frame({16'($urandom), $urandom}, {16'($urandom), $urandom}, 16'($urandom),
                    1'($urandom_range(0, 1)), 12'($urandom), p, 1'($urandom_range(0, 1)));
      end
      wait_drain();

      // Reset while the payload is flowing
      rdy_mode = 0;
      p.delete();
      for (int i = 0; i < 24; i++) p.push_back(8'(8'h80 + i));
      push_expected(T_DST, T_SRC, 16'h0800, 1'b0, 12'h000, p);
      send_hdr(T_DST, T_SRC, 16'h0800, 1'b0, 12'h000);
      send_beat(64'h8786858483828180, 8'hFF, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("midrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("midrst_s_axis_tready", 64'(s_axis_tready), 64'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("midrst_s_hdr_ready", 64'(s_hdr_ready), 64'd1);
      @(negedge clk);
      p.delete();
      for (int i = 0; i < 8; i++) p.push_back(8'(i));
      send_frame(T_DST, T_SRC, 16'h0800, 1'b0, 12'h000, p, 1'b0);
      wait_drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
